// File: rtl/logicnet_input_quantizer.sv
// LogicNet front-end: quantizes signed feature samples to 2-bit codes and packs NUM_FEAT codes per vector.
// Optional s_last frame checking is compiled in with `define LOGICNET_FRAME_CHECK_EN.
module logicnet_input_quantizer #(
  parameter int FEAT_W   = 16,
  parameter int NUM_FEAT = 8,
  parameter int CODE_W   = 2,
  localparam int NUM_THR = NUM_FEAT * 3,
  localparam int ADDR_W  = $clog2(NUM_THR),
  localparam int IDX_W   = $clog2(NUM_FEAT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [FEAT_W-1:0]            s_data,
  input  logic                         s_last,
  input  logic                         cfg_we,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [FEAT_W-1:0]            cfg_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_FEAT*CODE_W-1:0]   m_data,
  output logic                         frame_err,
  output logic [15:0]                  err_count
);

  localparam logic [FEAT_W-1:0] T_HI = {2'b01, {(FEAT_W-2){1'b0}}};
  localparam logic [FEAT_W-1:0] T_LO = {2'b11, {(FEAT_W-2){1'b0}}};

  logic signed [FEAT_W-1:0]      thr [NUM_THR];
  logic [IDX_W-1:0]              idx;
  logic [NUM_FEAT*CODE_W-1:0]    asm_q;
  logic [NUM_FEAT*CODE_W-1:0]    vec_next;
  logic [ADDR_W-1:0]             base;
  logic signed [FEAT_W-1:0]      x;
  logic signed [FEAT_W-1:0]      t0;
  logic signed [FEAT_W-1:0]      t1;
  logic signed [FEAT_W-1:0]      t2;
  logic [CODE_W-1:0]             code;
  logic                          last_slot;
  logic                          accept;
  logic                          complete;
  logic                          early;
  logic                          late;

  assign x         = s_data;
  assign last_slot = (idx == IDX_W'(NUM_FEAT-1));
  // Only the completing sample needs the output buffer, so only it is back-pressured.
  assign s_ready   = !last_slot || !m_valid || m_ready;
  assign accept    = s_valid && s_ready;
  assign complete  = accept && last_slot;

  always_comb begin
    base = ADDR_W'(3 * int'(idx));
    t0   = thr[base];
    t1   = thr[base + ADDR_W'(1)];
    t2   = thr[base + ADDR_W'(2)];
    code = CODE_W'(x >= t0) + CODE_W'(x >= t1) + CODE_W'(x >= t2);
  end

  always_comb begin
    vec_next = asm_q;
    for (int i = 0; i < NUM_FEAT; i++) begin
      if (idx == IDX_W'(i)) begin
        vec_next[i*CODE_W +: CODE_W] = code;
      end
    end
  end

`ifdef LOGICNET_FRAME_CHECK_EN
  logic        frame_err_q;
  logic [15:0] err_count_q;

  assign early = accept && s_last && !last_slot;
  assign late  = accept && !s_last && last_slot;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      frame_err_q <= early || late;
      if ((early || late) && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign frame_err = frame_err_q;
  assign err_count = err_count_q;
`else
  logic unused_s_last;

  assign unused_s_last = s_last;
  assign early         = 1'b0;
  assign late          = 1'b0;
  assign frame_err     = 1'b0;
  assign err_count     = '0;
`endif

  // Assembly slot index and single-entry output buffer with pass-through.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      asm_q   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (complete) begin
        m_data  <= vec_next;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (accept) begin
        asm_q <= vec_next;
        if (last_slot || early) begin
          idx <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  // Threshold table; a sample quantized in the write cycle still sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THR; i++) begin
        case (i % 3)
          0:       thr[i] <= T_LO;
          1:       thr[i] <= '0;
          default: thr[i] <= T_HI;
        endcase
      end
    end else if (cfg_we && (cfg_addr < ADDR_W'(NUM_THR))) begin
      thr[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Scoreboard bench for logicnet_input_quantizer: arithmetic reference model feeds an expected-vector queue,
// a negedge monitor compares every presented vector and handshake signal.
module tb_logicnet_input_quantizer;

  localparam int FEAT_W   = 16;
  localparam int NUM_FEAT = 8;
  localparam int NT       = NUM_FEAT * 3;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        frame_err;
  logic [15:0] err_count;

  logicnet_input_quantizer dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .frame_err(frame_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          thrM [NT];
  int          codesM [NUM_FEAT];
  int          cntM;
  logic [15:0] expQ [$];
  bit          expFerr;
  int          expErrCnt;
  logic [15:0] lastOut;
  int          outCount = 0;
  bit          firstAfterReset = 1'b0;
  bit          randReady = 1'b0;
  logic        readyCtl = 1'b1;
  int          boundary [11] = '{-16385, -16384, -16383, -1, 0, 1, 16383, 16384, 16385, -32768, 32767};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int quant(input int xv, input int f);
    int c = 0;
    if (xv >= thrM[f*3])   c++;
    if (xv >= thrM[f*3+1]) c++;
    if (xv >= thrM[f*3+2]) c++;
    return c;
  endfunction

  function automatic logic [15:0] packCodes();
    logic [15:0] v = '0;
    for (int i = 0; i < NUM_FEAT; i++) begin
      int c = codesM[i];
      v[2*i +: 2] = c[1:0];
    end
    return v;
  endfunction

  function automatic void resetModel();
    for (int i = 0; i < NT; i++) begin
      thrM[i] = (i % 3 == 0) ? -16384 : (i % 3 == 1) ? 0 : 16384;
    end
    for (int i = 0; i < NUM_FEAT; i++) codesM[i] = 0;
    cntM      = 0;
    expQ.delete();
    expFerr   = 1'b0;
    expErrCnt = 0;
  endfunction

  function automatic void bumpErr();
    expFerr = 1'b1;
    if (expErrCnt < 65535) expErrCnt++;
  endfunction

  function automatic void modelAccept(input int xv, input bit last);
    int f = cntM;
    codesM[f] = quant(xv, f);
`ifdef LOGICNET_FRAME_CHECK_EN
    if (last && f != NUM_FEAT-1) begin
      cntM = 0;
      bumpErr();
      return;
    end
    if (!last && f == NUM_FEAT-1) bumpErr();
`endif
    if (f == NUM_FEAT-1) begin
      expQ.push_back(packCodes());
      cntM = 0;
    end else begin
      cntM++;
    end
  endfunction

  // Monitor: compares outputs against the model, then folds this cycle's transfers into the model.
  always @(negedge clk) begin
    bit expReady;
    if (rst) begin
      resetModel();
      firstAfterReset = 1'b1;
    end else begin
      if (firstAfterReset) begin
        checkOutput("reset_m_data", m_data, 32'h0);
        firstAfterReset = 1'b0;
      end
      expReady = (cntM != NUM_FEAT-1) || (expQ.size() == 0) || m_ready;
      checkOutput("m_valid", m_valid, expQ.size() > 0);
      checkOutput("s_ready", s_ready, expReady);
      checkOutput("frame_err", frame_err, expFerr);
      checkOutput("err_count", err_count, expErrCnt);
      if (m_valid && expQ.size() > 0) checkOutput("m_data", m_data, expQ[0]);
      if (m_valid && m_ready && expQ.size() > 0) begin
        lastOut = m_data;
        outCount++;
        void'(expQ.pop_front());
      end
      expFerr = 1'b0;
      if (s_valid && s_ready) modelAccept($signed(s_data), s_last);
      if (cfg_we && cfg_addr < NT) thrM[cfg_addr] = $signed(cfg_data);
    end
  end

  always @(posedge clk) begin
    #1;
    if (randReady) m_ready = ($urandom_range(0, 3) != 0);
    else           m_ready = readyCtl;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] xv, input bit last);
    bit accepted = 1'b0;
    int n = 0;
    s_data  = xv;
    s_last  = last;
    s_valid = 1'b1;
    while (!accepted && n < 200) begin
      @(negedge clk);
      accepted = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL sample_timeout: got no accept expected accept within 200 cycles");
    end
    s_valid = 1'b0;
  endtask

  task automatic cfgWrite(input int addr, input int data);
    cfg_addr = 5'(addr);
    cfg_data = 16'(data);
    cfg_we   = 1'b1;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  function automatic logic [15:0] pickVal();
    if ($urandom_range(0, 1) == 0) return 16'($urandom);
    return 16'(boundary[$urandom_range(0, 10)]);
  endfunction

  initial begin
    int vals [NUM_FEAT] = '{-20000, -16384, -1, 0, 16383, 16384, 32767, -32768};
    int base;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; m_ready = 1'b1;
    tick(3);
    rst = 1'b0;

    $display("[TB] default thresholds, directed vector");
    for (int i = 0; i < NUM_FEAT; i++) applyStimulus(16'(vals[i]), i == NUM_FEAT-1);
    tick(3);
    checkOutput("vec_default", lastOut, 32'h3E94);

    $display("[TB] output back-pressure");
    base = outCount;
    readyCtl = 1'b0;
    tick(1);
    for (int i = 0; i < NUM_FEAT; i++) applyStimulus(pickVal(), i == NUM_FEAT-1);
    for (int i = 0; i < NUM_FEAT-1; i++) applyStimulus(pickVal(), 1'b0);
    fork
      applyStimulus(pickVal(), 1'b1);
      begin
        tick(6);
        readyCtl = 1'b1;
      end
    join
    tick(3);
    checkOutput("bp_vector_count", outCount - base, 2);

    $display("[TB] feature 2 threshold programming");
    cfgWrite(6, 100);
    cfgWrite(7, 200);
    cfgWrite(8, 300);
    for (int i = 0; i < NUM_FEAT; i++) applyStimulus(16'd150, i == NUM_FEAT-1);
    tick(3);
    checkOutput("vec_cfg", lastOut, 32'hAA9A);

    $display("[TB] back-to-back frames");
    base = outCount;
    for (int i = 0; i < 4 * NUM_FEAT; i++) applyStimulus(pickVal(), (i % NUM_FEAT) == NUM_FEAT-1);
    tick(3);
    checkOutput("b2b_vector_count", outCount - base, 4);

    $display("[TB] reset mid-frame");
    cfgWrite(0, 5000);
    for (int i = 0; i < 3; i++) applyStimulus(pickVal(), 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    base = outCount;
    for (int i = 0; i < NUM_FEAT; i++) applyStimulus(16'd0, i == NUM_FEAT-1);
    tick(3);
    checkOutput("reset_vector_count", outCount - base, 1);
    checkOutput("vec_after_reset", lastOut, 32'hAAAA);

`ifdef LOGICNET_FRAME_CHECK_EN
    $display("[TB] frame misalignment");
    base = outCount;
    for (int i = 0; i < 5; i++) applyStimulus(pickVal(), i == 4);
    tick(3);
    checkOutput("early_last_no_output", outCount - base, 0);
    checkOutput("early_last_err_count", err_count, 1);
    for (int i = 0; i < NUM_FEAT; i++) applyStimulus(pickVal(), i == NUM_FEAT-1);
    tick(3);
    checkOutput("resync_vector_count", outCount - base, 1);
    for (int i = 0; i < NUM_FEAT; i++) applyStimulus(pickVal(), 1'b0);
    tick(3);
    checkOutput("missing_last_vector_count", outCount - base, 2);
    checkOutput("missing_last_err_count", err_count, 2);
`endif

    $display("[TB] randomized traffic with config writes");
    randReady = 1'b1;
    fork
      begin
        int pos = 0;
        for (int i = 0; i < 200; i++) begin
          bit last = (pos == NUM_FEAT-1);
`ifdef LOGICNET_FRAME_CHECK_EN
          if ($urandom_range(0, 19) == 0) last = !last;
`endif
          applyStimulus(pickVal(), last);
          pos = (pos + 1) % NUM_FEAT;
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          tick($urandom_range(1, 20));
          cfgWrite($urandom_range(0, 31), 32'(pickVal()));
        end
      end
    join
    randReady = 1'b0;
    readyCtl  = 1'b1;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
